// File: rtl/q22_channel_scheduler.sv
// ---------------------------------------------------------------------------
// q22_channel_scheduler
//
// Purpose: selects one of four 24-bit signed sample channels per cycle and
// moves it into a single registered output stage as a Q22 sample. The sample
// keeps its sign bit and drops its LSB. Two arbitration modes are provided:
//   - round-robin (cfg_frame = 0): a rotating pointer picks among the enabled
//     channels that have a valid sample.
//   - frame (cfg_frame = 1): every channel enabled when the frame starts is
//     granted exactly once, in ascending order. The last sample of the frame
//     is tagged with m_last.
//
// Optional build macro: Q22_SCHED_CH0_PRIO_EN. When it is defined, channel 0
// wins every round-robin decision it takes part in and does not move the
// pointer. Frame mode is the same with or without the macro.
//
// Ports:
//   clk         sole clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   cfg_enable  [3:0]  per-channel enable mask
//   cfg_frame          0 = round-robin mode, 1 = frame mode
//   s_valid     [3:0]  per-channel sample valid
//   s_data      [95:0] channel i sample at bits [24i+23:24i]
//   s_ready     [3:0]  per-channel accept (one-hot or zero)
//   m_valid            output sample valid
//   m_ready            downstream accept
//   m_data      [22:0] Q22 output sample
//   m_chan      [1:0]  source channel of m_data
//   m_last             last sample of a frame
//   busy               output pending or frame in progress
// ---------------------------------------------------------------------------
module q22_channel_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cfg_enable,
  input  logic        cfg_frame,
  input  logic [3:0]  s_valid,
  input  logic [95:0] s_data,
  output logic [3:0]  s_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [22:0] m_data,
  output logic [1:0]  m_chan,
  output logic        m_last,
  output logic        busy
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  cur;
  logic [3:0]  frame_mask;

  logic        load_ok;
  logic [3:0]  rr_cand;
  logic        rr_found;
  logic [1:0]  rr_sel;
  logic [1:0]  lo_en;
  logic        frame_start;
  logic        in_frame;
  logic [3:0]  f_mask;
  logic [1:0]  f_cur;
  logic        nxt_found;
  logic [1:0]  nxt;
  logic [1:0]  sel;
  logic        found;
  logic        grant;
  logic        last_now;
  logic [23:0] chosen;

  // Arbitration. The output stage can take a sample whenever it is empty or
  // is being drained in this same cycle. In frame mode the IDLE state makes
  // its start decision and its first grant in one cycle, which is why the
  // frame selection reads cfg_enable directly while the state is IDLE.
  always_comb begin
    load_ok = !m_valid || m_ready;

    // Round-robin search starting at ptr. The loop runs from the farthest
    // candidate down to the nearest, so the nearest valid channel wins.
    rr_cand  = cfg_enable & s_valid;
    rr_found = 1'b0;
    rr_sel   = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (rr_cand[ptr + 2'(k)]) begin
        rr_found = 1'b1;
        rr_sel   = ptr + 2'(k);
      end
    end
`ifdef Q22_SCHED_CH0_PRIO_EN
    if (rr_cand[0]) begin
      rr_found = 1'b1;
      rr_sel   = 2'd0;
    end
`endif

    lo_en = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cfg_enable[i]) lo_en = 2'(i);
    end

    frame_start = (state == IDLE) && cfg_frame && (cfg_enable != 4'd0);
    in_frame    = (state == COLLECT) || frame_start;
    f_mask      = (state == COLLECT) ? frame_mask : cfg_enable;
    f_cur       = (state == COLLECT) ? cur : lo_en;

    // Next higher channel in the frame. If there is none, f_cur is the last.
    nxt_found = 1'b0;
    nxt       = f_cur;
    for (int i = 3; i >= 0; i--) begin
      if (f_mask[i] && (i > int'(f_cur))) begin
        nxt_found = 1'b1;
        nxt       = 2'(i);
      end
    end

    sel      = in_frame ? f_cur : rr_sel;
    found    = in_frame ? s_valid[f_cur] : rr_found;
    grant    = !reset && load_ok && found;
    last_now = in_frame && !nxt_found;

    case (sel)
      2'd0:    chosen = s_data[23:0];
      2'd1:    chosen = s_data[47:24];
      2'd2:    chosen = s_data[71:48];
      default: chosen = s_data[95:72];
    endcase

    s_ready = grant ? (4'b0001 << sel) : 4'b0000;
  end

  // Output register, round-robin pointer and frame FSM. A grant always
  // reloads the output stage, so a pop and an accept in the same cycle keep
  // m_valid high and the stage sustains one sample per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cur        <= 2'd0;
      frame_mask <= 4'd0;
      m_valid    <= 1'b0;
      m_data     <= 23'd0;
      m_chan     <= 2'd0;
      m_last     <= 1'b0;
    end else begin
      if (grant) begin
        m_valid <= 1'b1;
        m_data  <= {chosen[23], chosen[22:1]};
        m_chan  <= sel;
        m_last  <= last_now;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

`ifdef Q22_SCHED_CH0_PRIO_EN
      if (grant && !in_frame && (rr_sel != 2'd0)) ptr <= rr_sel + 2'd1;
`else
      if (grant && !in_frame) ptr <= rr_sel + 2'd1;
`endif

      case (state)
        IDLE: begin
          // A one-channel frame that is granted right away ends in the
          // same cycle, so the FSM stays in IDLE.
          if (frame_start) begin
            frame_mask <= cfg_enable;
            if (grant && last_now) begin
              state <= IDLE;
            end else if (grant) begin
              state <= COLLECT;
              cur   <= nxt;
            end else begin
              state <= COLLECT;
              cur   <= f_cur;
            end
          end
        end
        COLLECT: begin
          if (grant) begin
            if (last_now) state <= IDLE;
            else          cur   <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = m_valid || (state == COLLECT);

endmodule

// File: tb/tb_q22_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_q22_channel_scheduler
//
// Self-checking bench for q22_channel_scheduler. It runs table-driven
// vectors, several hand-written multi-cycle sequences, and a randomized run
// that is compared against a reference model. The model tracks frame
// progress as a queue of pending channels.
// ---------------------------------------------------------------------------
module tb_q22_channel_scheduler;

`ifdef Q22_SCHED_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  cfg_enable;
  logic        cfg_frame;
  logic [3:0]  s_valid;
  logic [95:0] s_data;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic        m_ready;
  logic [22:0] m_data;
  logic [1:0]  m_chan;
  logic        m_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  q22_channel_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_enable (cfg_enable),
    .cfg_frame  (cfg_frame),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sample;
    logic [22:0] exp_data;
  } conv_vec_t;

  conv_vec_t conv_tab[6];
  int        rr_seq[5];

  // Reference model state
  bit          mv;
  bit          ml;
  logic [22:0] md;
  logic [1:0]  mc;
  int          mptr;
  int          fq[$];

  function automatic logic [22:0] expData(input logic [23:0] raw);
    logic signed [23:0] x;
    x = raw;
    return 23'(x >>> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic fr, input logic [3:0] val, input logic rdy);
    @(negedge clk);
    cfg_enable = en;
    cfg_frame  = fr;
    s_valid    = val;
    m_ready    = rdy;
  endtask

  task automatic stepCheck();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput({tag, "_rst_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_rst_m_data"},  32'(m_data),  32'd0);
    checkOutput({tag, "_rst_m_chan"},  32'(m_chan),  32'd0);
    checkOutput({tag, "_rst_m_last"},  32'(m_last),  32'd0);
    checkOutput({tag, "_rst_s_ready"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "_rst_busy"},    32'(busy),    32'd0);
    cfg_enable = 4'd0;
    cfg_frame  = 1'b0;
    s_valid    = 4'd0;
    m_ready    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          sel;
    bit          found;
    bit          grant;
    bit          frame_now;
    bit          rst_now;
    int          lst[$];
    logic [3:0]  exp_rdy;

    conv_tab[0] = '{24'h800001, 23'h400000};
    conv_tab[1] = '{24'h000003, 23'h000001};
    conv_tab[2] = '{24'h7FFFFF, 23'h3FFFFF};
    conv_tab[3] = '{24'hFFFFFF, 23'h7FFFFF};
    conv_tab[4] = '{24'h000000, 23'h000000};
    conv_tab[5] = '{24'h800000, 23'h400000};
    rr_seq      = '{0, 1, 2, 3, 0};

    reset      = 1'b1;
    cfg_enable = 4'd0;
    cfg_frame  = 1'b0;
    s_valid    = 4'd0;
    s_data     = '0;
    m_ready    = 1'b1;
    #12;

    // Round-robin rotation with all channels ready
    $display("[TB] round-robin rotation");
    doReset("rr");
    s_data = {24'h400000, 24'h300000, 24'h200000, 24'h100000};
    applyStimulus(4'hF, 1'b0, 4'hF, 1'b1);
    #1;
    checkOutput("rr_s_ready0", 32'(s_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      stepCheck();
      checkOutput($sformatf("rr_chan%0d", i), 32'(m_chan), 32'(rr_seq[i]));
      checkOutput($sformatf("rr_last%0d", i), 32'(m_last), 32'd0);
      checkOutput($sformatf("rr_valid%0d", i), 32'(m_valid), 32'd1);
    end

    // Sample conversion table through channel 2
    $display("[TB] conversion table");
    doReset("conv");
    applyStimulus(4'b0100, 1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_data[71:48] = conv_tab[i].sample;
      stepCheck();
      checkOutput($sformatf("conv_data%0d", i), 32'(m_data), 32'(conv_tab[i].exp_data));
      checkOutput($sformatf("conv_chan%0d", i), 32'(m_chan), 32'd2);
    end

    // Frame with channel 1 arriving late, then a back-to-back frame
    $display("[TB] frame late channel");
    doReset("frm");
    applyStimulus(4'b1010, 1'b1, 4'b1000, 1'b1);
    #1;
    checkOutput("frm_wait_ready", 32'(s_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      stepCheck();
      checkOutput($sformatf("frm_wait_valid%0d", i), 32'(m_valid), 32'd0);
      checkOutput($sformatf("frm_wait_sready%0d", i), 32'(s_ready), 32'd0);
      checkOutput($sformatf("frm_wait_busy%0d", i), 32'(busy), 32'd1);
    end
    applyStimulus(4'b1010, 1'b1, 4'b1010, 1'b1);
    #1;
    checkOutput("frm_ch1_ready", 32'(s_ready), 32'h2);
    stepCheck();
    checkOutput("frm_g1_chan", 32'(m_chan), 32'd1);
    checkOutput("frm_g1_last", 32'(m_last), 32'd0);
    checkOutput("frm_ch3_ready", 32'(s_ready), 32'h8);
    stepCheck();
    checkOutput("frm_g2_chan", 32'(m_chan), 32'd3);
    checkOutput("frm_g2_last", 32'(m_last), 32'd1);
    checkOutput("frm_b2b_ready", 32'(s_ready), 32'h2);
    stepCheck();
    checkOutput("frm_b2b_chan", 32'(m_chan), 32'd1);
    checkOutput("frm_b2b_last", 32'(m_last), 32'd0);
    applyStimulus(4'b0000, 1'b0, 4'b1000, 1'b1);
    #1;
    checkOutput("frm_cfg_ignored", 32'(s_ready), 32'h8);
    stepCheck();
    checkOutput("frm_g3_chan", 32'(m_chan), 32'd3);
    checkOutput("frm_g3_last", 32'(m_last), 32'd1);

    // Reset during a frame after one grant
    $display("[TB] reset mid-frame");
    applyStimulus(4'b1010, 1'b1, 4'b0010, 1'b1);
    stepCheck();
    checkOutput("mid_pre_chan", 32'(m_chan), 32'd1);
    checkOutput("mid_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_chan",  32'(m_chan),  32'd0);
    checkOutput("mid_rst_data",  32'(m_data),  32'd0);
    checkOutput("mid_rst_sready", 32'(s_ready), 32'd0);
    checkOutput("mid_rst_busy",  32'(busy),    32'd0);
    cfg_enable = 4'b1100;
    cfg_frame  = 1'b1;
    s_valid    = 4'b1100;
    m_ready    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_new_ready", 32'(s_ready), 32'h4);
    stepCheck();
    checkOutput("mid_new_chan0", 32'(m_chan), 32'd2);
    checkOutput("mid_new_last0", 32'(m_last), 32'd0);
    stepCheck();
    checkOutput("mid_new_chan1", 32'(m_chan), 32'd3);
    checkOutput("mid_new_last1", 32'(m_last), 32'd1);
    applyStimulus(4'b0000, 1'b0, 4'hF, 1'b1);
    #1;
    checkOutput("dis_sready", 32'(s_ready), 32'h0);
    stepCheck();
    checkOutput("dis_drain_valid", 32'(m_valid), 32'd0);
    checkOutput("dis_drain_busy",  32'(busy),    32'd0);

    // Downstream stall
    $display("[TB] output stall");
    doReset("stall");
    s_data = {24'h400008, 24'hA00006, 24'h100004, 24'hF00003};
    applyStimulus(4'hF, 1'b0, 4'hF, 1'b1);
    stepCheck();
    checkOutput("stall_first_chan", 32'(m_chan), 32'd0);
    applyStimulus(4'hF, 1'b0, 4'hF, 1'b0);
    #1;
    checkOutput("stall_sready", 32'(s_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      stepCheck();
      checkOutput($sformatf("stall_chan%0d", i), 32'(m_chan), 32'd0);
      checkOutput($sformatf("stall_data%0d", i), 32'(m_data), 32'(expData(s_data[23:0])));
      checkOutput($sformatf("stall_valid%0d", i), 32'(m_valid), 32'd1);
      checkOutput($sformatf("stall_sready%0d", i), 32'(s_ready), 32'd0);
    end
    applyStimulus(4'hF, 1'b0, 4'hF, 1'b1);
    #1;
    checkOutput("stall_release_ready", 32'(s_ready), 32'h2);
    stepCheck();
    checkOutput("stall_next_chan", 32'(m_chan), 32'd1);
    checkOutput("stall_next_data", 32'(m_data), 32'(expData(s_data[47:24])));

    // Channel 0 and 1 continuously valid
    $display("[TB] channel 0 priority behaviour");
    doReset("prio");
    applyStimulus(4'b0011, 1'b0, 4'b0011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepCheck();
      checkOutput($sformatf("prio_chan%0d", i), 32'(m_chan), PRIO ? 32'd0 : 32'(i % 2));
    end

    // Randomized run against the reference model
    $display("[TB] randomized run");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_now = (cyc == 0) || ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_enable = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom);
        cfg_frame  = 1'($urandom);
      end
      s_valid = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      s_data  = {$urandom, $urandom, $urandom};
      reset   = rst_now;
      #1;

      exp_rdy = 4'd0;
      grant   = 1'b0;
      lst     = {};
      sel     = 0;
      if (rst_now) begin
        mv = 1'b0; ml = 1'b0; md = '0; mc = '0; mptr = 0;
        fq = {};
      end else begin
        frame_now = 1'b0;
        found     = 1'b0;
        if (fq.size() > 0) begin
          frame_now = 1'b1;
          sel       = fq[0];
          found     = s_valid[sel];
        end else if (cfg_frame && (cfg_enable != 4'd0)) begin
          for (int i = 0; i < 4; i++) if (cfg_enable[i]) lst.push_back(i);
          frame_now = 1'b1;
          sel       = lst[0];
          found     = s_valid[sel];
        end else if (PRIO && cfg_enable[0] && s_valid[0]) begin
          sel   = 0;
          found = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (!found && cfg_enable[(mptr + k) % 4] && s_valid[(mptr + k) % 4]) begin
              sel   = (mptr + k) % 4;
              found = 1'b1;
            end
          end
        end
        grant   = found && (!mv || m_ready);
        exp_rdy = grant ? 4'(1 << sel) : 4'd0;
      end

      checkOutput("rnd_s_ready", 32'(s_ready), 32'(exp_rdy));
      checkOutput("rnd_m_valid", 32'(m_valid), 32'(mv));
      checkOutput("rnd_m_data",  32'(m_data),  32'(md));
      checkOutput("rnd_m_chan",  32'(m_chan),  32'(mc));
      checkOutput("rnd_m_last",  32'(m_last),  32'(ml));
      checkOutput("rnd_busy",    32'(busy),    32'(mv || (fq.size() > 0)));

      if (!rst_now) begin
        if (lst.size() > 0) fq = lst;
        if (grant) begin
          md = expData(s_data[sel*24 +: 24]);
          mc = 2'(sel);
          mv = 1'b1;
          if (frame_now) begin
            void'(fq.pop_front());
            ml = (fq.size() == 0);
          end else begin
            ml = 1'b0;
            if (!(PRIO && sel == 0)) mptr = (sel + 1) % 4;
          end
        end else if (mv && m_ready) begin
          mv = 1'b0;
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
